// File: rtl/qei_enc_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// Phase encoding, step direction and default parameter widths.
package qei_enc_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned CPR_W_DEF = 16;

  // Indexed by quadrature phase s: {A,B} = 00, 10, 11, 01 for s = 0..3.
  localparam logic [3:0][1:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2
  } dir_e;

endpackage

// File: rtl/qei_enc_prescaler.sv
// Edge-rate prescaler: asserts tick once every div+1 enabled cycles.
// The >= compare keeps a mid-count decrease of div from overshooting.
module qei_enc_prescaler
  import qei_enc_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] pcnt_q, pcnt_d;

  assign tick_o = enable_i && (pcnt_q >= div_i);

  always_comb begin
    pcnt_d = pcnt_q + DIV_W'(1);
    if (!enable_i || clear_i || tick_o) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/qei_encoder_gen.sv
// Quadrature encoder emulator stepping A/B/index toward a signed target position.
// Define QEI_ENC_INDEX_EN to build the angle counter and index output; otherwise qei_i is 0.
module qei_encoder_gen
  import qei_enc_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CPR_W = CPR_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] target,
  input  logic [DIV_W-1:0] div,
  input  logic [CPR_W-1:0] cpr,
  input  logic             load,
  output logic             qei_a,
  output logic             qei_b,
  output logic             qei_i,
  output logic [CNT_W-1:0] position,
  output logic             busy,
  output logic             done
);

  logic tick;

  qei_enc_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .enable_i (enable),
    .clear_i  (load),
    .div_i    (div),
    .tick_o   (tick)
  );

  dir_e             dir;
  logic [1:0]       s_q, s_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             a_q, b_q, done_q, done_d;
  logic [1:0]       ab_d;

  // load suppresses stepping; target is only sampled on a tick.
  always_comb begin
    dir = DIR_NONE;
    if (tick && !load) begin
      if ($signed(pos_q) < $signed(target)) begin
        dir = DIR_FWD;
      end else if ($signed(pos_q) > $signed(target)) begin
        dir = DIR_REV;
      end
    end
  end

  always_comb begin
    s_d    = s_q;
    pos_d  = pos_q;
    done_d = 1'b0;
    unique case (dir)
      DIR_FWD: begin
        s_d    = s_q + 2'd1;
        pos_d  = pos_q + CNT_W'(1);
        done_d = (pos_d == target);
      end
      DIR_REV: begin
        s_d    = s_q - 2'd1;
        pos_d  = pos_q - CNT_W'(1);
        done_d = (pos_d == target);
      end
      default: ;
    endcase
    if (load) begin
      pos_d = target;
    end
  end

  assign ab_d = PHASE_AB[s_d];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s_q    <= 2'd0;
      pos_q  <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      pos_q  <= pos_d;
      a_q    <= ab_d[1];
      b_q    <= ab_d[0];
      done_q <= done_d;
    end
  end

`ifdef QEI_ENC_INDEX_EN
  logic [CPR_W-1:0] angle_q, angle_d;
  logic             qei_i_q, qei_i_d;

  // Out-of-range angle (cpr shrank) snaps to 0 going forward, cpr-1 going back.
  always_comb begin
    angle_d = angle_q;
    qei_i_d = qei_i_q;
    if (dir == DIR_FWD) begin
      if (cpr == '0 || angle_q >= cpr - CPR_W'(1)) begin
        angle_d = '0;
      end else begin
        angle_d = angle_q + CPR_W'(1);
      end
    end else if (dir == DIR_REV) begin
      if (cpr == '0) begin
        angle_d = '0;
      end else if (angle_q == '0 || angle_q >= cpr) begin
        angle_d = cpr - CPR_W'(1);
      end else begin
        angle_d = angle_q - CPR_W'(1);
      end
    end
    if (dir != DIR_NONE) begin
      qei_i_d = (angle_d == '0) && (cpr != '0);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      angle_q <= '0;
      qei_i_q <= 1'b0;
    end else begin
      angle_q <= angle_d;
      qei_i_q <= qei_i_d;
    end
  end

  assign qei_i = qei_i_q;
`else
  logic unused_cpr;
  assign unused_cpr = ^cpr;
  assign qei_i      = 1'b0;
`endif

  assign qei_a    = a_q;
  assign qei_b    = b_q;
  assign position = pos_q;
  assign done     = done_q;
  assign busy     = (pos_q != target);

endmodule

// File: tb/tb_qei_encoder_gen.sv
// Self-checking bench for qei_encoder_gen: expected edge events are queued with the stimulus
// and matched against events observed on the outputs.
module tb_qei_encoder_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic [31:0] target;
  logic [15:0] div;
  logic [15:0] cpr;
  logic        load;
  logic        qei_a, qei_b, qei_i, busy, done;
  logic [31:0] position;

  typedef struct packed {
    int          cyc;
    logic [1:0]  ab;
    logic [31:0] pos;
    logic        done;
    logic        qi;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  qei_encoder_gen dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (enable),
    .target    (target),
    .div       (div),
    .cpr       (cpr),
    .load      (load),
    .qei_a     (qei_a),
    .qei_b     (qei_b),
    .qei_i     (qei_i),
    .position  (position),
    .busy      (busy),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [1:0] ab_of(int p);
    int s;
    s = ((p % 4) + 4) % 4;
    case (s)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic push_exp(input int cyc, input int pos, input logic dn, input logic qi);
    ev_t e;
    e.cyc  = cyc;
    e.ab   = ab_of(pos);
    e.pos  = pos;
    e.done = dn;
    e.qi   = qi;
    exp_q.push_back(e);
  endtask

  // Record every cycle where any registered output changes or done is high.
  task automatic capture(input int ncyc);
    logic [1:0]  pab;
    logic [31:0] ppos;
    logic        pqi;
    ev_t         ev;
    pab  = {qei_a, qei_b};
    ppos = position;
    pqi  = qei_i;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge sys_clk);
      if ({qei_a, qei_b} !== pab || position !== ppos || qei_i !== pqi || done !== 1'b0) begin
        ev.cyc  = c;
        ev.ab   = {qei_a, qei_b};
        ev.pos  = position;
        ev.done = done;
        ev.qi   = qei_i;
        obs_q.push_back(ev);
      end
      pab  = {qei_a, qei_b};
      ppos = position;
      pqi  = qei_i;
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    target    = '0;
    div       = '0;
    cpr       = '0;
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    target    = '0;
    div       = '0;
    cpr       = '0;
    #1;
    n_vec++;
    if ({qei_a, qei_b, qei_i, done, busy} !== 5'b0 || position !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state got ab=%b%b i=%b done=%b busy=%b pos=%0d need all 0",
               qei_a, qei_b, qei_i, done, busy, position);
    end
    target = 32'd7;
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_busy got busy=%b need 1", busy);
    end
    target = '0;
    do_reset();
  endtask

  task automatic test_forward();
    ev_t e, o;
    do_reset();
    div = 16'd3; target = 32'd5; enable = 1'b1;
    for (int k = 1; k <= 5; k++) push_exp(4 * k, k, k == 5, 1'b0);
    capture(28);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL fwd_edge got cyc=%0d ab=%b pos=%0d done=%b qi=%b need cyc=%0d ab=%b pos=%0d done=%b qi=%b",
                 o.cyc, o.ab, $signed(o.pos), o.done, o.qi, e.cyc, e.ab, $signed(e.pos), e.done, e.qi);
      end
    end
    n_vec++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_tail got extra=%0d busy=%b need 0 and 0", obs_q.size(), busy);
    end
  endtask

  task automatic test_reverse();
    ev_t e, o;
    do_reset();
    div = 16'd1; target = -32'sd3; enable = 1'b1;
    for (int k = 1; k <= 3; k++) push_exp(2 * k, -k, k == 3, 1'b0);
    capture(14);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL rev_edge got cyc=%0d ab=%b pos=%0d done=%b need cyc=%0d ab=%b pos=%0d done=%b",
                 o.cyc, o.ab, $signed(o.pos), o.done, e.cyc, e.ab, $signed(e.pos), e.done);
      end
    end
    n_vec++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rev_tail got extra=%0d busy=%b need 0 and 0", obs_q.size(), busy);
    end
  endtask

  task automatic test_index();
    ev_t  e, o;
    logic qi;
    do_reset();
    cpr = 16'd8; div = 16'd0; target = 32'd20; enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
`ifdef QEI_ENC_INDEX_EN
      qi = (k == 8) || (k == 16);
`else
      qi = 1'b0;
`endif
      push_exp(k, k, k == 20, qi);
    end
    capture(26);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL index_edge got cyc=%0d pos=%0d qi=%b done=%b need cyc=%0d pos=%0d qi=%b done=%b",
                 o.cyc, $signed(o.pos), o.qi, o.done, e.cyc, $signed(e.pos), e.qi, e.done);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL index_extra got %0d extra events need 0", obs_q.size());
    end
  endtask

  task automatic test_pause();
    ev_t e, o;
    do_reset();
    div = 16'd4; target = 32'd100; enable = 1'b1;
    push_exp(5, 1, 1'b0, 1'b0);
    push_exp(10, 2, 1'b0, 1'b0);
    capture(10);
    enable = 1'b0;
    capture(10);
    enable = 1'b1;
    push_exp(5, 3, 1'b0, 1'b0);
    capture(7);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL pause_edge got cyc=%0d ab=%b pos=%0d need cyc=%0d ab=%b pos=%0d",
                 o.cyc, o.ab, $signed(o.pos), e.cyc, e.ab, $signed(e.pos));
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL pause_extra got %0d extra events need 0", obs_q.size());
    end
  endtask

  task automatic test_load();
    ev_t e, o;
    do_reset();
    div = 16'd0; target = 32'd100; enable = 1'b1;
    for (int k = 1; k <= 40; k++) push_exp(k, k, 1'b0, 1'b0);
    capture(40);
    target = 32'd1000; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    n_vec++;
    if (position !== 32'd1000 || {qei_a, qei_b} !== ab_of(40) || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL load_apply got pos=%0d ab=%b busy=%b done=%b need pos=1000 ab=%b busy=0 done=0",
               position, {qei_a, qei_b}, busy, done, ab_of(40));
    end
    capture(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL load_edge got cyc=%0d ab=%b pos=%0d done=%b need cyc=%0d ab=%b pos=%0d done=%b",
                 o.cyc, o.ab, $signed(o.pos), o.done, e.cyc, e.ab, $signed(e.pos), e.done);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL load_extra got %0d extra events need 0", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    do_reset();
    div = 16'd0; target = 32'd10; enable = 1'b1;
    for (int k = 1; k <= 6; k++) push_exp(k, k, 1'b0, 1'b0);
    capture(6);
    target = 32'd2;
    for (int k = 1; k <= 4; k++) push_exp(k, 6 - k, k == 4, 1'b0);
    capture(8);
    target = 32'd50;
    for (int k = 1; k <= 5; k++) push_exp(k, 2 + k, 1'b0, 1'b0);
    capture(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL b2b_edge got cyc=%0d ab=%b pos=%0d done=%b need cyc=%0d ab=%b pos=%0d done=%b",
                 o.cyc, o.ab, $signed(o.pos), o.done, e.cyc, e.ab, $signed(e.pos), e.done);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_extra got %0d extra events need 0", obs_q.size());
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({qei_a, qei_b, qei_i, done} !== 4'b0 || position !== 32'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset got ab=%b%b i=%b done=%b pos=%0d busy=%b need 0 0 0 0 pos=0 busy=1",
               qei_a, qei_b, qei_i, done, position, busy);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_index();
    test_pause();
    test_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qei_encoder_gen.md
# qei_encoder_gen

Quadrature encoder emulator: generates A/B/index signals that step a virtual encoder toward a commanded signed position at a programmable edge rate. It drives the motion controller's QEI decoder inputs (qei_a/qei_b/qei_i) for in-system loopback self-test, and can also drive an external quadrature-input drive. It is the transmitter for the decoder's receiver.

## Interface
Parameters:
- CNT_W, 32: width of position/target (signed, two's complement)
- DIV_W, 16: width of edge-rate divider
- CPR_W, 16: width of counts-per-revolution

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  run stepping; low freezes outputs and clears prescaler
- target  in  CNT_W  commanded position in quadrature counts (signed)
- div  in  DIV_W  one quadrature edge every div+1 cycles
- cpr  in  CPR_W  quadrature counts per revolution; 0 disables index
- load  in  1  re-reference: position := target, no edges emitted
- qei_a  out  1  channel A
- qei_b  out  1  channel B
- qei_i  out  1  index
- position  out  CNT_W  current virtual position (signed)
- busy  out  1  position != target (combinational)
- done  out  1  one-cycle pulse when a step makes position == target

## Operation
- Quadrature phase s in 0..3; {A,B} = 00,10,11,01 for s = 0,1,2,3. Forward (A leads B): s+1 mod 4, position+1. Reverse: s-1 mod 4, position-1.
- Prescaler pcnt: tick when enable and pcnt >= div, then pcnt := 0; otherwise pcnt+1. pcnt := 0 while !enable or load. The >= compare makes a mid-count decrease of div safe.
- On tick: signed compare. position < target steps forward, > steps reverse, == does nothing.
- Angle counter (0..cpr-1) tracks steps. Forward wraps cpr-1 -> 0; reverse wraps 0 -> cpr-1.
- qei_i is registered. On each step it takes (angle_next == 0 && cpr != 0), so it is high for exactly one quadrature state per revolution.
- If cpr changes and angle >= cpr: the next forward step goes to 0, the next reverse step goes to cpr-1.
- load has priority over tick: position := target, and s, angle, A/B, qei_i are unchanged. No done pulse.
- done fires only on a step, not when target is moved onto position.
- Reset values: qei_a=0, qei_b=0, qei_i=0, position=0, done=0, s=0, angle=0, pcnt=0.
- sys_rst_n low mid-move forces all state to reset values immediately.
- Position never wraps: stepping stops at target, and target is within the signed range.

## Timing
- All outputs except busy are registered. A tick in cycle N updates A/B/qei_i/position/done at the end of cycle N.
- After enable rises with pcnt=0, the first edge occurs div+1 cycles later. Subsequent edges are spaced exactly div+1 cycles apart.
- div=0 gives one edge per cycle.
- A target change is sampled at the next tick, which allows direction reversal between consecutive edges.
- busy follows target combinationally in the same cycle.

## Configuration
- QEI_ENC_INDEX_EN defined: angle counter and qei_i generation are present as above.
- QEI_ENC_INDEX_EN undefined: angle counter is removed, qei_i is tied 0, and the cpr port remains but is ignored.

## Structure
- Package qei_enc_pkg holds:
  - the phase-to-{A,B} encoding constant array
  - the direction enum (DIR_NONE, DIR_FWD, DIR_REV)
  - default parameter constants
- Sub-module qei_enc_prescaler (pcnt, div compare, tick output) is instantiated once. The step/angle/output logic lives in the top.

## Test plan
1. div=3, target=5, enable from reset -> A/B go 10,11,01,00,10, one edge every 4 cycles; position=5; a single done pulse with the 5th edge; busy=0 afterwards.
2. Start at 0, div=1, target=-3 -> A/B go 01,11,10, edges every 2 cycles; position=-3; done pulses once.
3. QEI_ENC_INDEX_EN defined, cpr=8, div=0, target=20 -> qei_i high exactly when position=8 and when position=16, one cycle each; low otherwise.
4. div=4, after 2 edges drop enable for 10 cycles -> A/B/position frozen. After re-enable, the next edge comes exactly 5 cycles later.
5. While busy toward target=100 at position=40, pulse load with target=1000 -> position=1000 next cycle, A/B unchanged, busy=0, no done pulse.
6. div=0, target=10; at position=6 set target=2 -> the next edge is a reverse step (position=5); the move ends at 2 with one done pulse. Asserting sys_rst_n low mid-move zeroes all outputs immediately.
